// File: rtl/module_debounce_ctrl.sv
// Button debounce filter with sticky edge events, an IRQ mask and a
// 4-word CPU register window (STATUS, EVENTS, IRQ_EN, CTRL).
module module_debounce_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Entering WAIT_* is already the first stable cycle, so the count
  // tops out one short of the usual terminal value.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_e;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic             enable_q;
  logic             edge_sel_q;
  logic [N_BTN-1:0] irq_en_q;
  logic [N_BTN-1:0] events_q;
  logic             irq_q;

  logic             enable_d;
  logic             edge_sel_d;
  logic [N_BTN-1:0] irq_en_d;
  logic [N_BTN-1:0] events_d;
  logic             irq_d;

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] ev_set;
  logic [N_BTN-1:0] ev_clr;
  logic             wr_ev;
  logic             wr_ien;
  logic             wr_ctrl;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      level[i] = (state_q[i] == IDLE_HI) ||
                 (state_q[i] == WAIT_LO);
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise[i]    = 1'b0;
      fall[i]    = 1'b0;
      if (!enable_q) begin
        state_d[i] = IDLE_LO;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          IDLE_LO: begin
            if (btn_i[i]) begin
              state_d[i] = WAIT_HI;
              cnt_d[i]   = '0;
            end
          end
          WAIT_HI: begin
            if (!btn_i[i]) begin
              state_d[i] = IDLE_LO;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == LAST) begin
              state_d[i] = IDLE_HI;
              cnt_d[i]   = '0;
              rise[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          IDLE_HI: begin
            if (!btn_i[i]) begin
              state_d[i] = WAIT_LO;
              cnt_d[i]   = '0;
            end
          end
          WAIT_LO: begin
            if (btn_i[i]) begin
              state_d[i] = IDLE_HI;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == LAST) begin
              state_d[i] = IDLE_LO;
              cnt_d[i]   = '0;
              fall[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  assign wr_ev   = we_i && (addr_i == 2'd1);
  assign wr_ien  = we_i && (addr_i == 2'd2);
  assign wr_ctrl = we_i && (addr_i == 2'd3);

  always_comb begin
    ev_set     = edge_sel_q ? fall : rise;
    ev_clr     = wr_ev ? wdata_i[N_BTN-1:0] : '0;
    events_d   = (events_q & ~ev_clr) | ev_set;
    irq_en_d   = wr_ien ? wdata_i[N_BTN-1:0] : irq_en_q;
    enable_d   = wr_ctrl ? wdata_i[0] : enable_q;
    edge_sel_d = wr_ctrl ? wdata_i[1] : edge_sel_q;
    irq_d      = |(events_d & irq_en_d);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE_LO;
        cnt_q[i]   <= '0;
      end
      enable_q   <= 1'b1;
      edge_sel_q <= 1'b0;
      irq_en_q   <= '0;
      events_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      irq_en_q   <= irq_en_d;
      events_q   <= events_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      2'd0: rdata_o = 32'(level & {N_BTN{enable_q}});
      2'd1: rdata_o = 32'(events_q);
      2'd2: rdata_o = 32'(irq_en_q);
      2'd3: rdata_o = {30'b0, edge_sel_q, enable_q};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_module_debounce_ctrl.sv
// Bench for module_debounce_ctrl: directed scenarios plus a random phase,
// checked against a run-length reference model of the debounce rules.
module tb_module_debounce_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [N-1:0] btn_i;
  logic [1:0]  addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state
  logic [N-1:0] m_lvl;
  int           m_run [N];
  logic [N-1:0] m_ev;
  logic [N-1:0] m_ien;
  logic         m_en;
  logic         m_esel;

  module_debounce_ctrl #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .btn_i(btn_i),
    .addr_i(addr_i),
    .we_i(we_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl  = '0;
    m_ev   = '0;
    m_ien  = '0;
    m_en   = 1'b1;
    m_esel = 1'b0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  function automatic logic [31:0] m_reg(input int a);
    case (a)
      0: return 32'(m_en ? m_lvl : '0);
      1: return 32'(m_ev);
      2: return 32'(m_ien);
      default: return {30'b0, m_esel, m_en};
    endcase
  endfunction

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr_i = a;
    #1;
    v = rdata_o;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    chk({tag, "_irq"}, 32'(irq_o), 32'(|(m_ev & m_ien)));
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("%s_a%0d", tag, a), v, m_reg(a));
    end
  endtask

  task automatic tick(input string tag, input logic [N-1:0] b,
                      input logic w, input logic [1:0] a,
                      input logic [31:0] d);
    logic [N-1:0] set;
    logic [N-1:0] clr;
    btn_i   = b;
    we_i    = w;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk);
    set = '0;
    clr = '0;
    // A level is accepted once the input has differed from it for D cycles in a row.
    for (int i = 0; i < N; i++) begin
      if (!m_en) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
      end else if (b[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = b[i];
          m_run[i] = 0;
          set[i]   = (b[i] != m_esel);
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (w) begin
      case (a)
        2'd1: clr = d[N-1:0];
        2'd2: m_ien = d[N-1:0];
        2'd3: begin
          m_en   = d[0];
          m_esel = d[1];
        end
        default: ;
      endcase
    end
    m_ev = (m_ev & ~clr) | set;
    #1;
    we_i = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic [N-1:0] b, input int n);
    for (int k = 0; k < n; k++) tick(tag, b, 1'b0, 2'd0, 32'h0);
  endtask

  logic [31:0] v;
  logic [N-1:0] rb;
  logic [31:0] rd_w;

  initial begin
    reset_i = 1'b0;
    btn_i   = '0;
    addr_i  = '0;
    we_i    = 1'b0;
    wdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    rd(2'd3, v);
    chk("rst_ctrl", v, 32'h1);
    @(negedge clk);
    reset_i = 1'b1;

    // single press and release of btn0
    idle("p0", 4'b0001, 3);
    rd(2'd0, v);
    chk("p0_early", v, 32'h0);
    idle("p0", 4'b0001, 1);
    rd(2'd0, v);
    chk("p0_status", v, 32'h1);
    rd(2'd1, v);
    chk("p0_events", v, 32'h1);
    idle("r0", 4'b0000, 4);
    rd(2'd0, v);
    chk("r0_status", v, 32'h0);
    rd(2'd1, v);
    chk("r0_events", v, 32'h1);
    tick("clr", 4'b0000, 1'b1, 2'd1, 32'hFFFF_FFFF);

    // glitching btn1 never settles
    for (int k = 0; k < 20; k++)
      tick("glitch", (k % 4 == 3) ? 4'b0000 : 4'b0010, 1'b0, 2'd0, 32'h0);
    rd(2'd0, v);
    chk("glitch_status", v, 32'h0);
    rd(2'd1, v);
    chk("glitch_events", v, 32'h0);

    // irq path and W1C vs set collision on btn2
    tick("ien", 4'b0000, 1'b1, 2'd2, 32'hFFFF_FFF4);
    idle("p2", 4'b0100, 4);
    chk("p2_irq", 32'(irq_o), 32'h1);
    rd(2'd1, v);
    chk("p2_events", v, 32'h4);
    tick("w1c2", 4'b0100, 1'b1, 2'd1, 32'h4);
    chk("w1c2_irq", 32'(irq_o), 32'h0);
    idle("r2", 4'b0000, 4);
    idle("p2b", 4'b0100, 3);
    tick("coll", 4'b0100, 1'b1, 2'd1, 32'h4);
    rd(2'd1, v);
    chk("coll_events", v, 32'h4);
    chk("coll_irq", 32'(irq_o), 32'h1);
    tick("clr2", 4'b0100, 1'b1, 2'd1, 32'h4);
    idle("r2b", 4'b0000, 4);

    // disable while held, then re-enable with button still high
    idle("p0d", 4'b0001, 4);
    tick("dis", 4'b0001, 1'b1, 2'd3, 32'h0);
    rd(2'd0, v);
    chk("dis_status", v, 32'h0);
    idle("dis_hold", 4'b0001, 3);
    tick("dis_clr", 4'b0001, 1'b1, 2'd1, 32'h1);
    tick("ena", 4'b0001, 1'b1, 2'd3, 32'h1);
    idle("ena_hold", 4'b0001, 4);
    rd(2'd0, v);
    chk("ena_status", v, 32'h1);
    idle("r0d", 4'b0000, 4);
    tick("clr3", 4'b0000, 1'b1, 2'd1, 32'hF);

    // falling-edge selection on btn3
    tick("esel", 4'b0000, 1'b1, 2'd3, 32'h3);
    idle("p3", 4'b1000, 4);
    rd(2'd1, v);
    chk("p3_events", v, 32'h0);
    idle("r3", 4'b0000, 3);
    rd(2'd1, v);
    chk("r3_early", v, 32'h0);
    idle("r3", 4'b0000, 1);
    rd(2'd1, v);
    chk("r3_events", v, 32'h8);

    // async reset in the middle of WAIT_HI
    tick("esel1", 4'b0000, 1'b1, 2'd3, 32'h1);
    tick("ienf", 4'b0000, 1'b1, 2'd2, 32'hF);
    idle("p0r", 4'b0001, 3);
    #1;
    reset_i = 1'b0;
    #1;
    model_reset();
    chk("arst_irq", 32'(irq_o), 32'h0);
    rd(2'd0, v);
    chk("arst_status", v, 32'h0);
    rd(2'd1, v);
    chk("arst_events", v, 32'h0);
    @(negedge clk);
    reset_i = 1'b1;
    idle("post", 4'b0001, 3);
    rd(2'd0, v);
    chk("post_early", v, 32'h0);
    idle("post", 4'b0001, 1);
    rd(2'd0, v);
    chk("post_status", v, 32'h1);

    // random phase
    rb = 4'b0001;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(4) == 0) rb[i] = ~rb[i];
      if ($urandom_range(9) == 0) begin
        rd_w = $urandom;
        v    = 32'($urandom_range(3));
        if (v == 32'd3 && $urandom_range(3) != 0) rd_w[0] = 1'b1;
        tick("rnd", rb, 1'b1, v[1:0], rd_w);
      end else begin
        tick("rnd", rb, 1'b0, 2'd0, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
